// File: rtl/mesh_pkg.sv
// mesh_pkg: header layout, field accessors and receiver FSM states for mesh terminal packets
package mesh_pkg;
  localparam int HDR_W = 17;
  typedef logic [HDR_W-1:0] hdr_t;
  typedef enum logic [1:0] {IDLE, POP, SETTLE} rx_state_e;
  function automatic int payload_w(int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction
  function automatic logic [7:0] get_nxtjp(hdr_t h);
    return h[16:9];
  endfunction
  function automatic logic [3:0] get_row(hdr_t h);
    return h[8:5];
  endfunction
  function automatic logic [3:0] get_col(hdr_t h);
    return h[4:1];
  endfunction
  function automatic logic get_mode(hdr_t h);
    return h[0];
  endfunction
endpackage

// File: rtl/mesh_term_rx_if.sv
// mesh_term_rx_if: mesh-side pop handshake, consumer-side show-ahead output and statistics
interface mesh_term_rx_if #(parameter int pckg_sz = 40, parameter int CNT_W = 16);
  logic pndng;
  logic [pckg_sz-1:0] data_out;
  logic pop;
  logic out_valid;
  logic [pckg_sz-18:0] out_payload;
  logic out_mode;
  logic [7:0] out_nxtjp;
  logic out_ready;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master(output pndng, data_out, out_ready,
                 input pop, out_valid, out_payload, out_mode, out_nxtjp, rx_cnt, err_cnt);
  modport slave(input pndng, data_out, out_ready,
                output pop, out_valid, out_payload, out_mode, out_nxtjp, rx_cnt, err_cnt);
endinterface

// File: rtl/term_fifo.sv
// term_fifo: synchronous show-ahead FIFO; dout reads zero while empty
module term_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/mesh_term_rx.sv
// mesh_term_rx: drains a mesh output port, keeps packets addressed here or broadcast, counts the rest as misrouted
module mesh_term_rx import mesh_pkg::*; #(
  parameter int         pckg_sz   = 40,
  parameter logic [3:0] TERM_ROW  = 4'd0,
  parameter logic [3:0] TERM_COL  = 4'd0,
  parameter logic [7:0] bdcst     = 8'hFF,
  parameter int         OUT_DEPTH = 4,
  parameter int         CNT_W     = 16
) (
  input logic clk,
  input logic reset,
  mesh_term_rx_if.slave bus
);
  localparam int PW = payload_w(pckg_sz);
  localparam int EW = PW + 9;
  localparam int AW = $clog2(OUT_DEPTH);
  rx_state_e state, nxt;
  logic [pckg_sz-1:0] hdr_q;
  logic [CNT_W-1:0] rx_cnt, err_cnt;
  logic [EW-1:0] head;
  logic [AW:0] fill;
  logic pop_q, push, drop, full, empty, match;
  hdr_t h;
  assign h = hdr_q[pckg_sz-1 -: HDR_W];
  assign match = {get_row(h), get_col(h)} == {TERM_ROW, TERM_COL} || {get_row(h), get_col(h)} == bdcst;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pop_q <= 1'b0;
      rx_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      pop_q <= nxt == POP;
      if (state == IDLE && nxt == POP) hdr_q <= bus.data_out;
      if (push && !(&rx_cnt)) rx_cnt <= rx_cnt + CNT_W'(1);
      if (drop && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end
  always_comb
    nxt = state == IDLE ? (bus.pndng && fill < (AW+1)'(OUT_DEPTH) ? POP : IDLE) :
          state == POP  ? SETTLE : IDLE;
  always_comb begin
    push = state == POP && match && !full;
    drop = state == POP && !match;
  end
  term_fifo #(.W(EW), .DEPTH(OUT_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(bus.out_ready),
    .din({get_nxtjp(h), get_mode(h), hdr_q[PW-1:0]}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fill)
  );
  assign bus.pop = pop_q;
  assign bus.out_valid = !empty;
  assign {bus.out_nxtjp, bus.out_mode, bus.out_payload} = head;
  assign bus.rx_cnt = rx_cnt;
  assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_mesh_term_rx.sv
// tb_mesh_term_rx: scenario tasks against a queue-based mesh and acceptance model
module tb_mesh_term_rx;
  localparam int PS = 40;
  localparam int CW = 4;
  localparam int D = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mesh_term_rx_if #(.pckg_sz(PS), .CNT_W(CW)) bus ();
  mesh_term_rx #(.pckg_sz(PS), .TERM_ROW(4'h0), .TERM_COL(4'h2), .bdcst(8'hFF),
                 .OUT_DEPTH(D), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [PS-1:0] mesh_q[$];
  logic [PS-1:0] exp_q[$];
  int pop_at[$];
  int exp_rx, exp_err, cyc_n, nchk, nfail;

  function automatic logic [PS-1:0] mk(logic [7:0] nx, logic [7:0] dest, logic mode, logic [22:0] pl);
    return {nx, dest, mode, pl};
  endfunction

  function automatic bit accepts(logic [PS-1:0] p);
    return p[31:24] == 8'h02 || p[31:24] == 8'hFF;
  endfunction

  task automatic drive_mesh();
    bus.pndng = mesh_q.size() > 0;
    bus.data_out = mesh_q.size() > 0 ? mesh_q[0] : '0;
  endtask

  // advances one clock from negedge to negedge, updating the mesh and the expected FIFO contents
  task automatic cyc();
    logic p, c, r;
    logic [PS-1:0] pk;
    p = bus.pop;
    c = bus.out_valid && bus.out_ready;
    r = reset;
    if (p) pop_at.push_back(cyc_n);
    @(posedge clk);
    #1;
    cyc_n++;
    if (c && exp_q.size() > 0) void'(exp_q.pop_front());
    if (p && mesh_q.size() > 0) begin
      pk = mesh_q.pop_front();
      if (accepts(pk)) begin
        exp_q.push_back(pk);
        exp_rx = exp_rx == MAXC ? MAXC : exp_rx + 1;
      end else exp_err = exp_err == MAXC ? MAXC : exp_err + 1;
    end
    if (r) begin
      exp_q.delete();
      exp_rx = 0;
      exp_err = 0;
    end
    drive_mesh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    mesh_q.delete();
    drive_mesh();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pop_at.delete();
  endtask

  task automatic test_reset();
    do_reset();
    nchk += 6;
    if (bus.pop !== 1'b0) begin nfail++; $display("FAIL reset_pop got %b want 0", bus.pop); end
    if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    if (bus.out_payload !== 23'h0) begin nfail++; $display("FAIL reset_payload got %h want 0", bus.out_payload); end
    if ({bus.out_mode, bus.out_nxtjp} !== 9'h0) begin nfail++; $display("FAIL reset_mode_nxtjp got %h want 0", {bus.out_mode, bus.out_nxtjp}); end
    if (bus.rx_cnt !== 4'h0) begin nfail++; $display("FAIL reset_rx got %0d want 0", bus.rx_cnt); end
    if (bus.err_cnt !== 4'h0) begin nfail++; $display("FAIL reset_err got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_match();
    do_reset();
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b1, 23'h1));
    drive_mesh();
    cyc();
    nchk++;
    if (bus.pop !== 1'b1) begin nfail++; $display("FAIL match_pop_latency got %b want 1", bus.pop); end
    cyc();
    nchk += 6;
    if (bus.pop !== 1'b0) begin nfail++; $display("FAIL match_pop_width got %b want 0", bus.pop); end
    if (bus.out_valid !== 1'b1) begin nfail++; $display("FAIL match_valid got %b want 1", bus.out_valid); end
    if (bus.out_payload !== 23'h1) begin nfail++; $display("FAIL match_payload got %h want 1", bus.out_payload); end
    if (bus.out_mode !== 1'b1) begin nfail++; $display("FAIL match_mode got %b want 1", bus.out_mode); end
    if (bus.rx_cnt !== 4'd1) begin nfail++; $display("FAIL match_rx got %0d want 1", bus.rx_cnt); end
    if (bus.err_cnt !== 4'd0) begin nfail++; $display("FAIL match_err got %0d want 0", bus.err_cnt); end
    repeat (4) cyc();
    nchk++;
    if (pop_at.size() != 1) begin nfail++; $display("FAIL match_pop_count got %0d want 1", pop_at.size()); end
  endtask

  task automatic test_misroute();
    do_reset();
    mesh_q.push_back(mk(8'h00, 8'h12, 1'b1, 23'h3));
    drive_mesh();
    repeat (5) cyc();
    nchk += 4;
    if (pop_at.size() != 1) begin nfail++; $display("FAIL misroute_pop_count got %0d want 1", pop_at.size()); end
    if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL misroute_valid got %b want 0", bus.out_valid); end
    if (bus.err_cnt !== 4'd1) begin nfail++; $display("FAIL misroute_err got %0d want 1", bus.err_cnt); end
    if (bus.rx_cnt !== 4'd0) begin nfail++; $display("FAIL misroute_rx got %0d want 0", bus.rx_cnt); end
  endtask

  task automatic test_bdcst();
    do_reset();
    mesh_q.push_back(mk(8'hA5, 8'hFF, 1'b0, 23'h55));
    drive_mesh();
    repeat (2) cyc();
    nchk += 4;
    if (bus.out_valid !== 1'b1) begin nfail++; $display("FAIL bdcst_valid got %b want 1", bus.out_valid); end
    if (bus.out_payload !== 23'h55) begin nfail++; $display("FAIL bdcst_payload got %h want 55", bus.out_payload); end
    if (bus.out_nxtjp !== 8'hA5) begin nfail++; $display("FAIL bdcst_nxtjp got %h want a5", bus.out_nxtjp); end
    if (bus.rx_cnt !== 4'd1) begin nfail++; $display("FAIL bdcst_rx got %0d want 1", bus.rx_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [22:0] got[$];
    do_reset();
    for (int i = 1; i <= 6; i++) mesh_q.push_back(mk(8'h00, 8'h02, 1'b1, 23'(i)));
    drive_mesh();
    repeat (25) cyc();
    nchk += 4;
    if (pop_at.size() != 4) begin nfail++; $display("FAIL bp_pop_count got %0d want 4", pop_at.size()); end
    for (int i = 0; i + 1 < pop_at.size(); i++) begin
      nchk++;
      if (pop_at[i+1] - pop_at[i] != 3) begin nfail++; $display("FAIL bp_pop_gap got %0d want 3", pop_at[i+1] - pop_at[i]); end
    end
    if (bus.pop !== 1'b0) begin nfail++; $display("FAIL bp_pop_held got %b want 0", bus.pop); end
    if (bus.pndng !== 1'b1) begin nfail++; $display("FAIL bp_pndng got %b want 1", bus.pndng); end
    if (bus.rx_cnt !== 4'd4) begin nfail++; $display("FAIL bp_rx_full got %0d want 4", bus.rx_cnt); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && got.size() < 6; k++) begin
      if (bus.out_valid) got.push_back(bus.out_payload);
      cyc();
    end
    bus.out_ready = 1'b0;
    nchk += 2;
    if (got.size() != 6) begin nfail++; $display("FAIL bp_drain_count got %0d want 6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      nchk++;
      if (got[i] !== 23'(i + 1)) begin nfail++; $display("FAIL bp_order got %h want %h", got[i], i + 1); end
    end
    if (bus.rx_cnt !== 4'd6) begin nfail++; $display("FAIL bp_rx got %0d want 6", bus.rx_cnt); end
  endtask

  task automatic test_simul();
    int k;
    do_reset();
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b0, 23'hA));
    drive_mesh();
    repeat (3) cyc();
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b1, 23'hB));
    drive_mesh();
    for (k = 0; k < 6 && bus.pop !== 1'b1; k++) cyc();
    nchk++;
    if (bus.pop !== 1'b1) begin nfail++; $display("FAIL simul_pop_timeout got %b want 1", bus.pop); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    nchk += 3;
    if (bus.out_valid !== 1'b1) begin nfail++; $display("FAIL simul_valid got %b want 1", bus.out_valid); end
    if (bus.out_payload !== 23'hB) begin nfail++; $display("FAIL simul_head got %h want b", bus.out_payload); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL simul_count got valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_pop();
    do_reset();
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b1, 23'h1));
    mesh_q.push_back(mk(8'h00, 8'h31, 1'b1, 23'h2));
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b1, 23'h7));
    drive_mesh();
    repeat (7) cyc();
    nchk++;
    if (bus.pop !== 1'b1) begin nfail++; $display("FAIL rstpop_setup got pop %b want 1", bus.pop); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    nchk += 4;
    if (bus.pop !== 1'b0) begin nfail++; $display("FAIL rstpop_pop got %b want 0", bus.pop); end
    if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL rstpop_valid got %b want 0", bus.out_valid); end
    if (bus.rx_cnt !== 4'd0) begin nfail++; $display("FAIL rstpop_rx got %0d want 0", bus.rx_cnt); end
    if (bus.err_cnt !== 4'd0) begin nfail++; $display("FAIL rstpop_err got %0d want 0", bus.err_cnt); end
    mesh_q.push_back(mk(8'h00, 8'h02, 1'b0, 23'h9));
    drive_mesh();
    cyc();
    nchk++;
    if (bus.pop !== 1'b1) begin nfail++; $display("FAIL rstpop_idle got pop %b want 1", bus.pop); end
    cyc();
    nchk += 2;
    if (bus.out_payload !== 23'h9 || bus.out_valid !== 1'b1) begin nfail++; $display("FAIL rstpop_next got %b/%h want 1/9", bus.out_valid, bus.out_payload); end
    if (bus.rx_cnt !== 4'd1) begin nfail++; $display("FAIL rstpop_next_rx got %0d want 1", bus.rx_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] dest;
    int acc;
    do_reset();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: dest = 8'h02;
        1: dest = 8'hFF;
        default: dest = 8'($urandom);
      endcase
      mesh_q.push_back(mk(8'($urandom), dest, 1'($urandom), 23'($urandom)));
      if (accepts(mesh_q[i])) acc++;
    end
    drive_mesh();
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      nchk += 3;
      if (bus.out_valid !== (exp_q.size() > 0)) begin nfail++; $display("FAIL rand_valid got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.rx_cnt !== 4'(exp_rx)) begin nfail++; $display("FAIL rand_rx got %0d want %0d", bus.rx_cnt, exp_rx); end
      if (bus.err_cnt !== 4'(exp_err)) begin nfail++; $display("FAIL rand_err got %0d want %0d", bus.err_cnt, exp_err); end
      if (exp_q.size() > 0) begin
        nchk++;
        if ({bus.out_nxtjp, bus.out_mode, bus.out_payload} !== {exp_q[0][39:32], exp_q[0][23:0]})
          begin nfail++; $display("FAIL rand_head got %h want %h", {bus.out_nxtjp, bus.out_mode, bus.out_payload}, {exp_q[0][39:32], exp_q[0][23:0]}); end
      end
      cyc();
    end
    bus.out_ready = 1'b0;
    nchk++;
    if (mesh_q.size() != 0) begin nfail++; $display("FAIL rand_drain got %0d left want 0", mesh_q.size()); end
    if (acc >= MAXC) begin
      nchk++;
      if (bus.rx_cnt !== 4'hF) begin nfail++; $display("FAIL rand_saturate got %0d want 15", bus.rx_cnt); end
    end
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    cyc_n = 0;
    exp_rx = 0;
    exp_err = 0;
    bus.out_ready = 1'b0;
    drive_mesh();
    @(negedge clk);
    test_reset();
    test_match();
    test_misroute();
    test_bdcst();
    test_back_pressure();
    test_simul();
    test_reset_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mesh_term_rx.md
Name: mesh_term_rx

Overview:
- Terminal-side receiver for one mesh_gnrtr output port.
- Drains packets the mesh presents on pndng/data_out by pulsing pop.
- Decodes the header, checks the destination against this terminal's own coordinates (or broadcast), and buffers accepted packets in a small show-ahead FIFO for a consumer or checker.
- Counts accepted and misrouted packets. It is the output-end counterpart of the per-terminal input FIFOs that push into the mesh.

Parameters:
- pckg_sz, 40, packet width in bits.
- TERM_ROW, 0, this terminal's row id (4 bits).
- TERM_COL, 0, this terminal's column id (4 bits).
- bdcst, 8'hFF, broadcast destination id, compared against {row,colum}.
- OUT_DEPTH, 4, output FIFO depth in entries. Power of two, ≥2.
- CNT_W, 16, width of the statistic counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- pndng  in  1  mesh output FIFO non-empty; data_out is valid while high.
- data_out  in  pckg_sz  head packet of the mesh output FIFO.
- pop  out  1  one-cycle pulse that removes the mesh head packet.
- out_valid  out  1  output FIFO non-empty.
- out_payload  out  pckg_sz-17  payload of the output FIFO head.
- out_mode  out  1  mode bit of the output FIFO head.
- out_nxtjp  out  8  Nxtjp field of the output FIFO head.
- out_ready  in  1  consumer pop; ignored when out_valid=0.
- rx_cnt  out  CNT_W  accepted packets, saturating.
- err_cnt  out  CNT_W  misrouted packets (dropped), saturating.

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Packet fields:
  - Nxtjp = [pckg_sz-1:pckg_sz-8]
  - row = [pckg_sz-9:pckg_sz-12]
  - colum = [pckg_sz-13:pckg_sz-16]
  - mode = [pckg_sz-17]
  - payload = [pckg_sz-18:0]
- Reset values: pop=0, out_valid=0, out_payload/out_mode/out_nxtjp=0, rx_cnt=0, err_cnt=0. FSM goes to IDLE and the FIFO is empty.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if pndng=1 and FIFO count < OUT_DEPTH, latch data_out into hdr_q and go to POP. Otherwise stay.
  - POP: pop=1, driven from a register, so exactly this one cycle.
    - match = ({row,colum}=={TERM_ROW,TERM_COL}) || ({row,colum}==bdcst), evaluated on hdr_q.
    - match → push {Nxtjp,mode,payload} into the FIFO and increment rx_cnt.
    - no match → drop the packet and increment err_cnt.
    - Go to SETTLE.
  - SETTLE: one dead cycle so the mesh pndng reflects the pop, then go to IDLE.
- Latency and throughput:
  - pndng sampled in IDLE at cycle N → pop high in cycle N+1 → out_valid high in cycle N+2 if the FIFO was empty.
  - Maximum rate is one packet per 3 cycles.
- Full condition: the admission check is made in IDLE, and count cannot increase before the push. The FIFO therefore never overflows. While full, pop stays 0 and the mesh holds the packet.
- FIFO read/write:
  - Show-ahead: out_* always present the head entry.
  - out_ready && out_valid removes the head at the edge.
  - A push and a pop in the same cycle leave count unchanged, and data order is preserved.
  - Pointers are log2(OUT_DEPTH) bits and wrap naturally; count is log2(OUT_DEPTH)+1 bits.
- Counters saturate at all-ones. They never wrap.
- pndng dropping while the FSM is in POP is a mesh protocol violation; the FSM still completes POP and SETTLE using hdr_q.
- Reset mid-operation: reset asserted in any state forces IDLE and clears the FIFO and counters at that edge. A pop already high in that cycle still reaches the mesh; that packet is lost by design.

Decomposition:
- Package mesh_pkg:
  - field offset localparams or functions derived from pckg_sz;
  - get_row / get_col / get_mode / get_payload functions;
  - typedef rx_state_e {IDLE, POP, SETTLE}.
- Sub-module term_fifo: synchronous show-ahead FIFO parameterised by width and depth, with push, pop, full, empty and count.
- mesh_term_rx contains the FSM, the decode/match logic and the counters.

Test Plan (pckg_sz=40, TERM_ROW=0, TERM_COL=2, OUT_DEPTH=4):
1. Matching packet: data_out={8'h00,4'h0,4'h2,1'b1,23'h1}, pndng held until pop. Required: pop pulses once for one cycle, 1 cycle after pndng is sampled; out_valid rises the next cycle; out_payload=1, out_mode=1; rx_cnt=1, err_cnt=0.
2. Misrouted packet: row=4'h1, col=4'h2. Required: pop pulses once; out_valid stays 0; err_cnt=1, rx_cnt=0.
3. Broadcast packet: {row,colum}=8'hFF, payload=23'h55. Required: accepted; out_payload=23'h55; rx_cnt=1.
4. Back-pressure: 6 matching packets queued with out_ready=0. Required: exactly 4 pop pulses spaced 3 cycles apart, then pop=0 while pndng=1. Then raise out_ready: payloads 1..6 emerge in order and rx_cnt=6.
5. Simultaneous push and pop: FIFO holds 1 entry and out_ready=1 during a POP cycle. Required: count stays 1 and the next head is the new packet.
6. Reset in POP state: assert reset for 1 cycle. Required: the next cycle shows pop=0, out_valid=0 and rx_cnt=err_cnt=0; FSM in IDLE; a subsequent packet is received normally.
